// File: rtl/uart_pkg.sv
// Shared types and limits for the configurable UART receiver.
// Holds FSM state encodings, frame config bundle and legal bounds.
package uart_pkg;

    localparam int DATA_W_MAX_DEF = 9;
    localparam int PRESC_MIN      = 8;
    localparam int PRESC_MAX      = 32;
    localparam int DATA_LEN_MIN   = 5;
    localparam int BIT_CNT_W      = 5;
    // Longest legal frame is 13 bit periods; anything past this is runaway
    localparam int BIT_LIMIT      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic [3:0] data_len;
        logic       par_en;
        logic       par_typ;
        logic       stop2;
    } rx_cfg_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic cfg_legal(input int presc, input int len,
                                       input int dmax);
        return (presc >= PRESC_MIN) && (presc <= PRESC_MAX) &&
               (presc % 2 == 0) && (len >= DATA_LEN_MIN) && (len <= dmax);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge/bit counters and a
// three-sample majority voter centred on each bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PRESC_W-1:0]   prescale,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 maj_bit,
    output logic                 samp_done,
    output logic                 bit_end
);

    logic [PRESC_W-1:0]   edge_q, edge_d;
    logic [PRESC_W-1:0]   mid;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [2:0]           smp_q, smp_d;

    assign mid       = prescale >> 1;
    assign bit_end   = (edge_q == prescale - PRESC_W'(1));
    assign samp_done = (edge_q == mid + PRESC_W'(2));
    assign bit_cnt   = bit_q;
    assign maj_bit   = maj3(smp_q);

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        smp_d  = smp_q;
        if (clr) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (en) begin
            if (bit_end) begin
                edge_d = '0;
                bit_d  = bit_q + BIT_CNT_W'(1);
            end else begin
                edge_d = edge_q + PRESC_W'(1);
            end
            if (edge_q == mid - PRESC_W'(1)) smp_d[0] = rx_in;
            if (edge_q == mid)               smp_d[1] = rx_in;
            if (edge_q == mid + PRESC_W'(1)) smp_d[2] = rx_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= '0;
            bit_q  <= '0;
            smp_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
            smp_q  <= smp_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg_fsm.sv
// Configurable UART receiver: frame FSM, LSB-first shift register
// and parity check, with bit timing delegated to uart_rx_sampler.
module uart_rx_cfg_fsm
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX = DATA_W_MAX_DEF,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic [3:0]            DATA_LEN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_W_MAX-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    rx_state_e             state_q, state_d;
    rx_cfg_t               cfg_q, cfg_d;
    logic [DATA_W_MAX-1:0] shreg_q, shreg_d;
    logic [DATA_W_MAX-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  glitch_q, glitch_d;

    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  maj_bit;
    logic                  samp_done;
    logic                  bit_end;
    logic                  last_stop;
    logic                  par_exp;

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk       (CLK),
        .rst_n     (nRESET),
        .rx_in     (RX_IN),
        .en        (busy),
        .clr       (state_d == ST_IDLE),
        .prescale  (Prescale),
        .bit_cnt   (bit_cnt),
        .maj_bit   (maj_bit),
        .samp_done (samp_done),
        .bit_end   (bit_end)
    );

    assign busy      = (state_q != ST_IDLE);
    assign last_stop = (state_q == ST_STOP2) || !cfg_q.stop2;
    assign par_exp   = (^shreg_q) ^ cfg_q.par_typ;

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        shreg_d  = shreg_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        perr_d   = 1'b0;
        serr_d   = 1'b0;
        glitch_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!RX_IN && cfg_legal(int'(Prescale), int'(DATA_LEN),
                                        DATA_W_MAX)) begin
                    state_d = ST_START;
                    cfg_d   = '{DATA_LEN, PAR_EN, PAR_TYP, STOP2};
                    shreg_d = '0;
                end
            end
            ST_START: begin
                if (samp_done && maj_bit) begin
                    glitch_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (samp_done) begin
                    for (int i = 0; i < DATA_W_MAX; i++) begin
                        if (bit_cnt == BIT_CNT_W'(i + 1)) shreg_d[i] = maj_bit;
                    end
                end
                if (bit_end && bit_cnt >= BIT_CNT_W'(cfg_q.data_len)) begin
                    state_d = cfg_q.par_en ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (samp_done && (maj_bit != par_exp)) begin
                    perr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1, ST_STOP2: begin
                // Word already delivered: leave one cycle after the pulse
                if (dv_q) begin
                    state_d = ST_IDLE;
                end else if (samp_done && !maj_bit) begin
                    serr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (samp_done && last_stop) begin
                    dv_d     = 1'b1;
                    p_data_d = shreg_q;
                end else if (bit_end && state_q == ST_STOP1) begin
                    state_d = ST_STOP2;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (busy && bit_cnt >= BIT_CNT_W'(BIT_LIMIT)) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            cfg_q    <= '0;
            shreg_q  <= '0;
            p_data_q <= '0;
            dv_q     <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            shreg_q  <= shreg_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            perr_q   <= perr_d;
            serr_q   <= serr_d;
            glitch_q <= glitch_d;
        end
    end

    assign P_DATA      = p_data_q;
    assign data_valid  = dv_q;
    assign par_err     = perr_q;
    assign stp_err     = serr_q;
    assign strt_glitch = glitch_q;

endmodule
